// File: rtl/overlay_mixer.sv
// Composites the emblem overlay over the background with a per-frame wipe reveal/hold/hide
// animation and registers colour together with the syncs. OVERLAY_SCANLINE_EN dims odd background rows.
module overlay_mixer #(
    parameter int V_VISIBLE   = 480,
    parameter int WIPE_STEP   = 8,
    parameter int HOLD_FRAMES = 120
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       active,
    input  logic       hsync_in,
    input  logic       vsync_in,
    input  logic       ov_draw,
    input  logic [5:0] ov_rgb,
    input  logic [5:0] bg_rgb,
    input  logic       trigger,
    output logic [5:0] rgb_out,
    output logic       hsync_out,
    output logic       vsync_out,
    output logic       busy,
    output logic [1:0] state_o
);

    // state  | meaning
    // HIDDEN | overlay invisible, waiting for trigger
    // REVEAL | reveal line grows by WIPE_STEP per frame
    // SHOWN  | fully revealed, counting hold frames
    // HIDE   | reveal line shrinks by WIPE_STEP per frame
    typedef enum logic [1:0] {
        HIDDEN = 2'd0,
        REVEAL = 2'd1,
        SHOWN  = 2'd2,
        HIDE   = 2'd3
    } state_t;

    localparam logic [9:0]  LP_V    = 10'(V_VISIBLE);
    localparam logic [10:0] LP_STEP = 11'(WIPE_STEP);
    localparam logic [7:0]  LP_HOLD = 8'(HOLD_FRAMES - 1);

    state_t      r_state;
    logic [9:0]  r_reveal_line;
    logic [7:0]  r_hold_cnt;
    logic [5:0]  r_rgb;
    logic        r_hsync;
    logic        r_vsync;

    logic        w_frame_tick;
    logic [10:0] w_sum;
    logic [5:0]  w_bg;
    logic [5:0]  w_pix;

    assign w_frame_tick = (x == 10'd0) && (y == LP_V) && !active;
    assign w_sum        = {1'b0, r_reveal_line} + LP_STEP;

`ifdef OVERLAY_SCANLINE_EN
    assign w_bg = y[0] ? {1'b0, bg_rgb[5], 1'b0, bg_rgb[3], 1'b0, bg_rgb[1]} : bg_rgb;
`else
    assign w_bg = bg_rgb;
`endif

    always_comb begin
        w_pix = w_bg;
        if (!active)
            w_pix = 6'd0;
        else if (ov_draw && (y < r_reveal_line))
            w_pix = ov_rgb;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rgb   <= 6'd0;
            r_hsync <= 1'b0;
            r_vsync <= 1'b0;
        end else begin
            r_rgb   <= w_pix;
            r_hsync <= hsync_in;
            r_vsync <= vsync_in;
        end
    end

    // Trigger acts immediately in HIDDEN/SHOWN; everything else waits for the frame boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= HIDDEN;
            r_reveal_line <= 10'd0;
            r_hold_cnt    <= 8'd0;
        end else begin
            case (r_state)
                HIDDEN: begin
                    if (trigger)
                        r_state <= REVEAL;
                end
                REVEAL: begin
                    if (w_frame_tick) begin
                        if (w_sum >= {1'b0, LP_V}) begin
                            r_reveal_line <= LP_V;
                            r_hold_cnt    <= 8'd0;
                            r_state       <= SHOWN;
                        end else begin
                            r_reveal_line <= w_sum[9:0];
                        end
                    end
                end
                SHOWN: begin
                    if (trigger) begin
                        r_state <= HIDE;
                    end else if (w_frame_tick) begin
                        if (r_hold_cnt == LP_HOLD)
                            r_state <= HIDE;
                        else
                            r_hold_cnt <= r_hold_cnt + 8'd1;
                    end
                end
                HIDE: begin
                    if (w_frame_tick) begin
                        if ({1'b0, r_reveal_line} <= LP_STEP) begin
                            r_reveal_line <= 10'd0;
                            r_state       <= HIDDEN;
                        end else begin
                            r_reveal_line <= r_reveal_line - LP_STEP[9:0];
                        end
                    end
                end
                default: r_state <= HIDDEN;
            endcase
        end
    end

    assign rgb_out   = r_rgb;
    assign hsync_out = r_hsync;
    assign vsync_out = r_vsync;
    assign state_o   = r_state;
    assign busy      = (r_state == REVEAL) || (r_state == HIDE);

endmodule

// File: tb/tb_overlay_mixer.sv
// Randomized bench for overlay_mixer with a frame-level reference model of the wipe animation.
module tb_overlay_mixer;

    localparam int V  = 480;
    localparam int W  = 8;
    localparam int HF = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [9:0] x = '0, y = '0;
    logic       active = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0;
    logic       ov_draw = 1'b0, trigger = 1'b0;
    logic [5:0] ov_rgb = '0, bg_rgb = '0;
    logic [5:0] rgb_out;
    logic       hsync_out, vsync_out, busy;
    logic [1:0] state_o;

    int n_cmp = 0;
    int n_bad = 0;

    // reference model: 0 hidden, 1 reveal, 2 shown, 3 hide
    int m_state = 0;
    int m_line  = 0;
    int m_hold  = 0;

    overlay_mixer #(.V_VISIBLE(V), .WIPE_STEP(W), .HOLD_FRAMES(HF)) dut (
        .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active(active),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .ov_draw(ov_draw),
        .ov_rgb(ov_rgb), .bg_rgb(bg_rgb), .trigger(trigger),
        .rgb_out(rgb_out), .hsync_out(hsync_out), .vsync_out(vsync_out),
        .busy(busy), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [5:0] ref_pixel();
        logic [5:0] bg;
        bg = bg_rgb;
`ifdef OVERLAY_SCANLINE_EN
        if (y % 2 == 1)
            bg = {1'b0, bg_rgb[5], 1'b0, bg_rgb[3], 1'b0, bg_rgb[1]};
`endif
        if (!active) return 6'd0;
        if (ov_draw && (int'(y) < m_line)) return ov_rgb;
        return bg;
    endfunction

    task automatic model_step(input bit trig, input bit tick);
        if (trig && m_state == 0) begin
            m_state = 1;
        end else if (trig && m_state == 2) begin
            m_state = 3;
        end else if (tick) begin
            case (m_state)
                1: begin
                    if (m_line + W >= V) begin
                        m_line = V; m_hold = 0; m_state = 2;
                    end else m_line = m_line + W;
                end
                2: begin
                    if (m_hold == HF - 1) m_state = 3;
                    else m_hold++;
                end
                3: begin
                    if (m_line <= W) begin
                        m_line = 0; m_state = 0;
                    end else m_line = m_line - W;
                end
                default: ;
            endcase
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_line = 0; m_hold = 0;
    endtask

    // Inputs are already set; clock one edge and compare everything.
    task automatic drive_cycle();
        logic [5:0] e_rgb;
        logic       e_hs, e_vs;
        bit         tick, trig;
        e_rgb = ref_pixel();
        e_hs  = hsync_in;
        e_vs  = vsync_in;
        tick  = (x == 10'd0) && (int'(y) == V) && !active;
        trig  = trigger;
        @(posedge clk);
        #1;
        model_step(trig, tick);
        check_eq("rgb_out", 32'(rgb_out), 32'(e_rgb));
        check_eq("hsync_out", 32'(hsync_out), 32'(e_hs));
        check_eq("vsync_out", 32'(vsync_out), 32'(e_vs));
        check_eq("state_o", 32'(state_o), 32'(m_state));
        check_eq("busy", 32'(busy), 32'(m_state == 1 || m_state == 3));
        trigger = 1'b0;
    endtask

    task automatic set_pix(input int px, input int py, input bit act, input bit drw,
                           input logic [5:0] ov, input logic [5:0] bg);
        x = 10'(px); y = 10'(py); active = act; ov_draw = drw; ov_rgb = ov; bg_rgb = bg;
        hsync_in = 1'($urandom); vsync_in = 1'($urandom);
    endtask

    task automatic pixel_rand();
        int py;
        if ($urandom_range(0, 1) == 1) begin
            py = m_line + $urandom_range(0, 3) - 2;
            if (py < 0) py = 0;
        end else begin
            py = $urandom_range(0, 524);
        end
        x = 10'($urandom_range(0, 799));
        y = 10'(py);
        active = (x < 10'd640) && (py < V);
        if ($urandom_range(0, 9) == 0) active = ~active;
        ov_draw  = 1'($urandom);
        ov_rgb   = 6'($urandom);
        bg_rgb   = 6'($urandom);
        hsync_in = 1'($urandom);
        vsync_in = 1'($urandom);
    endtask

    task automatic frame(input int npix, input int trig_pct);
        for (int i = 0; i < npix; i++) begin
            pixel_rand();
            trigger = ($urandom_range(0, 99) < trig_pct);
            drive_cycle();
        end
        pixel_rand();
        x = 10'd0; y = 10'(V); active = 1'b0;
        trigger = ($urandom_range(0, 99) < trig_pct);
        drive_cycle();
    endtask

    initial begin
        // asynchronous reset mid-line with an overlay pixel present
        set_pix(100, 10, 1'b1, 1'b1, 6'h2a, 6'h15);
        #3 rst_n = 1'b0;
        #1;
        check_eq("rst_rgb", 32'(rgb_out), 32'd0);
        check_eq("rst_hsync", 32'(hsync_out), 32'd0);
        check_eq("rst_vsync", 32'(vsync_out), 32'd0);
        check_eq("rst_state", 32'(state_o), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        set_pix(5, 5, 1'b1, 1'b1, 6'h30, 6'b000011);
        drive_cycle();
        check_eq("post_rst_bg", 32'(rgb_out), 32'b000011);

        // reveal from trigger, boundary pixel checks at line 24
        pixel_rand(); trigger = 1'b1; drive_cycle();
        for (int f = 0; f < 3; f++) frame(5, 0);
        set_pix(200, 23, 1'b1, 1'b1, 6'h2d, 6'h12); drive_cycle();
        check_eq("f3_y23", 32'(rgb_out), 32'h2d);
        set_pix(200, 24, 1'b1, 1'b1, 6'h2d, 6'h12); drive_cycle();
        check_eq("f3_y24", 32'(rgb_out), 32'h12);
        frame(5, 0); frame(5, 0);
        pixel_rand(); trigger = 1'b1; drive_cycle();
        check_eq("reveal_ign_trig", 32'(state_o), 32'd1);
        for (int f = 5; f < 60; f++) frame(5, 0);
        check_eq("shown_after_60", 32'(state_o), 32'd2);
        for (int f = 0; f < HF; f++) frame(4, 0);
        check_eq("auto_hide_state", 32'(state_o), 32'd3);
        check_eq("auto_hide_busy", 32'(busy), 32'd1);
        for (int f = 0; f < 60; f++) frame(4, 0);
        check_eq("hidden_state", 32'(state_o), 32'd0);
        check_eq("hidden_busy", 32'(busy), 32'd0);

        // early dismiss from SHOWN: line must still be 480 until the next tick
        pixel_rand(); trigger = 1'b1; drive_cycle();
        for (int f = 0; f < 60; f++) frame(3, 0);
        pixel_rand(); trigger = 1'b1; drive_cycle();
        check_eq("dismiss_state", 32'(state_o), 32'd3);
        set_pix(10, 479, 1'b1, 1'b1, 6'h3c, 6'h03); drive_cycle();
        check_eq("dismiss_line479", 32'(rgb_out), 32'h3c);
        frame(3, 0);
        set_pix(10, 472, 1'b1, 1'b1, 6'h3c, 6'h03); drive_cycle();
        check_eq("hide_line472", 32'(rgb_out), 32'h03);

        // random animation with sporadic triggers and one reset mid-sequence
        for (int f = 0; f < 300; f++) begin
            frame($urandom_range(2, 10), 4);
            if (f == 150) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("mid_rst_rgb", 32'(rgb_out), 32'd0);
                check_eq("mid_rst_state", 32'(state_o), 32'd0);
                check_eq("mid_rst_hsync", 32'(hsync_out), 32'd0);
                model_reset();
                #1 rst_n = 1'b1;
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
